// File: rtl/vec_dot_loader.sv
// Serial-to-parallel feeder for the 16-lane Q4.11 dot-product engine: fills two lane vectors,
// runs the engine and captures its result. Optional shadow buffer: VEC_LOADER_PREFETCH_EN.
module vec_dot_loader #(
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_a,
  input  logic [DW-1:0]         in_b,
  input  logic                  in_last,
  output logic [LANES*DW-1:0]   vec_a,
  output logic [LANES*DW-1:0]   vec_b,
  output logic                  dot_en,
  input  logic                  dot_finish,
  input  logic [DW-1:0]         dot_in,
  output logic                  res_valid,
  output logic [DW-1:0]         res_data,
  output logic                  busy
);

  localparam int unsigned VW = LANES * DW;
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LastLane = CW'(LANES - 1);

  localparam logic [1:0] StFill  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] va_q, va_d, vb_q, vb_d;
  logic          rv_q, rv_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          accept;

`ifdef VEC_LOADER_PREFETCH_EN
  logic [VW-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          sdone_q, sdone_d;

  // Outside FILL, pairs go to the shadow buffer until it holds a complete vector.
  assign in_ready = rst && ((state_q == StFill) || !sdone_q);
`else
  assign in_ready = rst && (state_q == StFill);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    va_d    = va_q;
    vb_d    = vb_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
`ifdef VEC_LOADER_PREFETCH_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    scnt_d  = scnt_q;
    sdone_d = sdone_q;
    if (accept && (state_q != StFill)) begin
      sa_d[scnt_q*DW +: DW] = in_a;
      sb_d[scnt_q*DW +: DW] = in_b;
      scnt_d                = scnt_q + CW'(1);
      sdone_d               = in_last || (scnt_q == LastLane);
    end
`endif
    case (state_q)
      StFill: begin
        // Unwritten lanes are already zero: the buffer is cleared on the way back to FILL.
        if (accept) begin
          va_d[cnt_q*DW +: DW] = in_a;
          vb_d[cnt_q*DW +: DW] = in_b;
          cnt_d                = cnt_q + CW'(1);
          if (in_last || (cnt_q == LastLane)) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (dot_finish) begin
          rd_d    = dot_in;
          rv_d    = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StGap;
      end
      default: begin
`ifdef VEC_LOADER_PREFETCH_EN
        // Hand over the shadow contents, including a pair accepted in this very cycle.
        va_d    = sa_d;
        vb_d    = sb_d;
        cnt_d   = scnt_d;
        state_d = sdone_d ? StRun : StFill;
        sa_d    = '0;
        sb_d    = '0;
        scnt_d  = '0;
        sdone_d = 1'b0;
`else
        va_d    = '0;
        vb_d    = '0;
        cnt_d   = '0;
        state_d = StFill;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFill;
      cnt_q   <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
`ifdef VEC_LOADER_PREFETCH_EN
      sa_q    <= '0;
      sb_q    <= '0;
      scnt_q  <= '0;
      sdone_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
`ifdef VEC_LOADER_PREFETCH_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      scnt_q  <= scnt_d;
      sdone_q <= sdone_d;
`endif
    end
  end

  assign vec_a     = va_q;
  assign vec_b     = vb_q;
  assign dot_en    = (state_q == StRun) || (state_q == StDrain);
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign busy      = !((state_q == StFill) && (cnt_q == '0));

endmodule
